// File: rtl/div_reservation_station_if.sv
// Divide-control type plus the flush/dispatch/CDB/issue bundle of the divide reservation station.
// The master modport is the upstream/divider side; the slave modport is the reservation station.
package div_rs_pkg;
   typedef struct packed {
      logic is_signed;
      logic alter_ov;
      logic alter_cr0;
   } div_decode_t;
endpackage

interface div_reservation_station_if #(
   parameter int RS_ID_WIDTH = 5,
   parameter int DEPTH       = 4
);
   import div_rs_pkg::*;

   logic                       flush;
   logic                       dispatch_valid;
   logic                       dispatch_ready;
   logic [RS_ID_WIDTH-1:0]     dispatch_rs_id;
   logic                       dispatch_op1_valid;
   logic [31:0]                dispatch_op1_value;
   logic [RS_ID_WIDTH-1:0]     dispatch_op1_tag;
   logic                       dispatch_op2_valid;
   logic [31:0]                dispatch_op2_value;
   logic [RS_ID_WIDTH-1:0]     dispatch_op2_tag;
   logic [4:0]                 dispatch_result_reg_addr;
   div_decode_t                dispatch_control;
   logic                       cdb_valid;
   logic [RS_ID_WIDTH-1:0]     cdb_rs_id;
   logic [31:0]                cdb_result;
   logic                       issue_valid;
   logic                       issue_ready;
   logic [RS_ID_WIDTH-1:0]     issue_rs_id;
   logic [4:0]                 issue_result_reg_addr;
   logic [31:0]                issue_op1;
   logic [31:0]                issue_op2;
   div_decode_t                issue_control;
   logic [$clog2(DEPTH+1)-1:0] occupancy;

   modport master (
      output flush, dispatch_valid, dispatch_op1_valid, dispatch_op1_value, dispatch_op1_tag,
             dispatch_op2_valid, dispatch_op2_value, dispatch_op2_tag, dispatch_result_reg_addr,
             dispatch_control, cdb_valid, cdb_rs_id, cdb_result, issue_ready,
      input  dispatch_ready, dispatch_rs_id, issue_valid, issue_rs_id, issue_result_reg_addr,
             issue_op1, issue_op2, issue_control, occupancy
   );

   modport slave (
      input  flush, dispatch_valid, dispatch_op1_valid, dispatch_op1_value, dispatch_op1_tag,
             dispatch_op2_valid, dispatch_op2_value, dispatch_op2_tag, dispatch_result_reg_addr,
             dispatch_control, cdb_valid, cdb_rs_id, cdb_result, issue_ready,
      output dispatch_ready, dispatch_rs_id, issue_valid, issue_rs_id, issue_result_reg_addr,
             issue_op1, issue_op2, issue_control, occupancy
   );
endinterface

// File: rtl/div_reservation_station.sv
// Reservation station feeding the divide unit: holds divw/divwu ops, snoops the CDB, issues lowest ready entry.
// Optional DIV_RS_CDB_FORWARD_EN: an entry woken by the current CDB broadcast issues in that same cycle.
module div_reservation_station #(
   parameter int RS_ID_WIDTH = 5,
   parameter int DEPTH       = 4,
   parameter int RS_BASE_ID  = 0
) (
   input logic                      clk,
   input logic                      rst,
   div_reservation_station_if.slave rs_if
);
   import div_rs_pkg::*;

   localparam int IDX_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic                   busy;
      logic                   op1_rdy;
      logic [31:0]            op1_val;
      logic [RS_ID_WIDTH-1:0] op1_tag;
      logic                   op2_rdy;
      logic [31:0]            op2_val;
      logic [RS_ID_WIDTH-1:0] op2_tag;
      logic [4:0]             reg_addr;
      div_decode_t            control;
   } entry_t;

   entry_t           entry_q [DEPTH];
   entry_t           entry_d [DEPTH];
   logic [DEPTH-1:0] busy, cand, wake1, wake2;
   logic             alloc_found, sel_found;
   logic [IDX_W-1:0] alloc_idx, sel_idx;
   logic [OCC_W-1:0] occ;
   logic             disp_fire, issue_fire, disp_op1_hit, disp_op2_hit;

   always_comb begin : wakeup
      busy  = '0;
      cand  = '0;
      wake1 = '0;
      wake2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         busy[i]  = entry_q[i].busy;
         wake1[i] = entry_q[i].busy & ~entry_q[i].op1_rdy & rs_if.cdb_valid &
                    (entry_q[i].op1_tag == rs_if.cdb_rs_id);
         wake2[i] = entry_q[i].busy & ~entry_q[i].op2_rdy & rs_if.cdb_valid &
                    (entry_q[i].op2_tag == rs_if.cdb_rs_id);
`ifdef DIV_RS_CDB_FORWARD_EN
         cand[i]  = entry_q[i].busy & (entry_q[i].op1_rdy | wake1[i]) &
                    (entry_q[i].op2_rdy | wake2[i]);
`else
         cand[i]  = entry_q[i].busy & entry_q[i].op1_rdy & entry_q[i].op2_rdy;
`endif
      end
   end

   // Scanning downwards lets the lowest index win both the free-slot and the issue search.
   always_comb begin : select
      alloc_found = 1'b0;
      alloc_idx   = '0;
      sel_found   = 1'b0;
      sel_idx     = '0;
      occ         = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         // NOTE: blocking assignments in combinational logic; every output has a default above so no latch forms.
         if (!busy[i]) begin
            alloc_found = 1'b1;
            alloc_idx   = IDX_W'(i);
         end
         if (cand[i]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
         end
         occ = occ + OCC_W'(busy[i]);
      end
   end

   assign rs_if.dispatch_ready        = alloc_found;
   assign rs_if.dispatch_rs_id        = RS_ID_WIDTH'(RS_BASE_ID) + RS_ID_WIDTH'(alloc_idx);
   assign rs_if.issue_valid           = sel_found;
   assign rs_if.issue_rs_id           = RS_ID_WIDTH'(RS_BASE_ID) + RS_ID_WIDTH'(sel_idx);
   assign rs_if.issue_result_reg_addr = entry_q[sel_idx].reg_addr;
   assign rs_if.issue_control         = entry_q[sel_idx].control;
   assign rs_if.occupancy             = occ;
`ifdef DIV_RS_CDB_FORWARD_EN
   assign rs_if.issue_op1 = wake1[sel_idx] ? rs_if.cdb_result : entry_q[sel_idx].op1_val;
   assign rs_if.issue_op2 = wake2[sel_idx] ? rs_if.cdb_result : entry_q[sel_idx].op2_val;
`else
   assign rs_if.issue_op1 = entry_q[sel_idx].op1_val;
   assign rs_if.issue_op2 = entry_q[sel_idx].op2_val;
`endif

   always_comb begin : next_state
      disp_fire    = rs_if.dispatch_valid & alloc_found;
      issue_fire   = sel_found & rs_if.issue_ready;
      disp_op1_hit = ~rs_if.dispatch_op1_valid & rs_if.cdb_valid &
                     (rs_if.dispatch_op1_tag == rs_if.cdb_rs_id);
      disp_op2_hit = ~rs_if.dispatch_op2_valid & rs_if.cdb_valid &
                     (rs_if.dispatch_op2_tag == rs_if.cdb_rs_id);
      for (int i = 0; i < DEPTH; i++) begin
         entry_d[i] = entry_q[i];
         if (wake1[i]) begin
            entry_d[i].op1_rdy = 1'b1;
            entry_d[i].op1_val = rs_if.cdb_result;
         end
         if (wake2[i]) begin
            entry_d[i].op2_rdy = 1'b1;
            entry_d[i].op2_val = rs_if.cdb_result;
         end
         if (issue_fire && sel_idx == IDX_W'(i)) entry_d[i].busy = 1'b0;
         // The allocated slot is never busy this cycle, so it cannot collide with the issuing one.
         if (disp_fire && alloc_idx == IDX_W'(i)) begin
            entry_d[i].busy     = 1'b1;
            entry_d[i].op1_rdy  = rs_if.dispatch_op1_valid | disp_op1_hit;
            entry_d[i].op1_val  = rs_if.dispatch_op1_valid ? rs_if.dispatch_op1_value : rs_if.cdb_result;
            entry_d[i].op1_tag  = rs_if.dispatch_op1_tag;
            entry_d[i].op2_rdy  = rs_if.dispatch_op2_valid | disp_op2_hit;
            entry_d[i].op2_val  = rs_if.dispatch_op2_valid ? rs_if.dispatch_op2_value : rs_if.cdb_result;
            entry_d[i].op2_tag  = rs_if.dispatch_op2_tag;
            entry_d[i].reg_addr = rs_if.dispatch_result_reg_addr;
            entry_d[i].control  = rs_if.dispatch_control;
         end
         if (rs_if.flush) entry_d[i].busy = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         entry_q[i] <= entry_d[i];
         // NOTE: only the busy bit is reset; payload is don't-care until its entry is busy again.
         if (rst) entry_q[i].busy <= 1'b0;
      end
   end
endmodule

// File: tb/tb_div_reservation_station.sv
// Directed self-checking bench for div_reservation_station (default build; DIV_RS_CDB_FORWARD_EN aware).
// Inputs change 1 time unit after the rising edge; outputs are compared mid-cycle.
module tb_div_reservation_station;
   import div_rs_pkg::*;

   localparam int RS_ID_WIDTH = 5;
   localparam int DEPTH       = 4;
   localparam int RS_BASE_ID  = 0;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   div_reservation_station_if #(.RS_ID_WIDTH(RS_ID_WIDTH), .DEPTH(DEPTH)) rs_if ();

   div_reservation_station #(
      .RS_ID_WIDTH(RS_ID_WIDTH),
      .DEPTH      (DEPTH),
      .RS_BASE_ID (RS_BASE_ID)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .rs_if(rs_if)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rs_if.flush                    = 1'b0;
      rs_if.dispatch_valid           = 1'b0;
      rs_if.dispatch_op1_valid       = 1'b0;
      rs_if.dispatch_op1_value       = '0;
      rs_if.dispatch_op1_tag         = '0;
      rs_if.dispatch_op2_valid       = 1'b0;
      rs_if.dispatch_op2_value       = '0;
      rs_if.dispatch_op2_tag         = '0;
      rs_if.dispatch_result_reg_addr = '0;
      rs_if.dispatch_control         = '0;
      rs_if.cdb_valid                = 1'b0;
      rs_if.cdb_rs_id                = '0;
      rs_if.cdb_result               = '0;
      rs_if.issue_ready              = 1'b0;
   endtask

   task automatic set_dispatch(input logic v1, input logic [31:0] val1, input logic [4:0] tag1,
                               input logic v2, input logic [31:0] val2, input logic [4:0] tag2,
                               input logic [4:0] rd, input logic [2:0] ctl);
      rs_if.dispatch_valid           = 1'b1;
      rs_if.dispatch_op1_valid       = v1;
      rs_if.dispatch_op1_value       = val1;
      rs_if.dispatch_op1_tag         = tag1;
      rs_if.dispatch_op2_valid       = v2;
      rs_if.dispatch_op2_value       = val2;
      rs_if.dispatch_op2_tag         = tag2;
      rs_if.dispatch_result_reg_addr = rd;
      rs_if.dispatch_control         = div_decode_t'(ctl);
   endtask

   task automatic set_cdb(input logic v, input logic [4:0] tag, input logic [31:0] val);
      rs_if.cdb_valid  = v;
      rs_if.cdb_rs_id  = tag;
      rs_if.cdb_result = val;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      checks++; if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL reset_issue_valid got=%0b want=0", rs_if.issue_valid); end
      checks++; if (rs_if.dispatch_ready !== 1'b1) begin failures++; $display("FAIL reset_dispatch_ready got=%0b want=1", rs_if.dispatch_ready); end
      checks++; if (rs_if.occupancy !== 3'd0) begin failures++; $display("FAIL reset_occupancy got=%0d want=0", rs_if.occupancy); end
      checks++; if (rs_if.dispatch_rs_id !== 5'd0) begin failures++; $display("FAIL reset_dispatch_rs_id got=%0d want=0", rs_if.dispatch_rs_id); end
      // A reset with a dispatch in flight discards both the entry and the dispatch.
      set_dispatch(1'b1, 32'd1, 5'd0, 1'b1, 32'd1, 5'd0, 5'd1, 3'b000);
      step();
      checks++; if (rs_if.occupancy !== 3'd1) begin failures++; $display("FAIL reset_pre_occupancy got=%0d want=1", rs_if.occupancy); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      rs_if.dispatch_valid = 1'b0;
      checks++; if (rs_if.occupancy !== 3'd0) begin failures++; $display("FAIL reset_mid_occupancy got=%0d want=0", rs_if.occupancy); end
      checks++; if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL reset_mid_issue_valid got=%0b want=0", rs_if.issue_valid); end
   endtask

   task automatic test_basic_issue();
      rs_if.issue_ready = 1'b1;
      set_dispatch(1'b1, 32'd100, 5'd0, 1'b1, 32'd7, 5'd0, 5'd3, 3'b101);
      checks++; if (rs_if.dispatch_ready !== 1'b1) begin failures++; $display("FAIL basic_dispatch_ready got=%0b want=1", rs_if.dispatch_ready); end
      checks++; if (rs_if.dispatch_rs_id !== 5'd0) begin failures++; $display("FAIL basic_dispatch_rs_id got=%0d want=0", rs_if.dispatch_rs_id); end
      step();
      rs_if.dispatch_valid = 1'b0;
      checks++; if (rs_if.issue_valid !== 1'b1) begin failures++; $display("FAIL basic_issue_valid got=%0b want=1", rs_if.issue_valid); end
      checks++; if (rs_if.issue_op1 !== 32'd100) begin failures++; $display("FAIL basic_op1 got=%0d want=100", rs_if.issue_op1); end
      checks++; if (rs_if.issue_op2 !== 32'd7) begin failures++; $display("FAIL basic_op2 got=%0d want=7", rs_if.issue_op2); end
      checks++; if (rs_if.issue_rs_id !== 5'd0) begin failures++; $display("FAIL basic_issue_rs_id got=%0d want=0", rs_if.issue_rs_id); end
      checks++; if (rs_if.issue_result_reg_addr !== 5'd3) begin failures++; $display("FAIL basic_reg_addr got=%0d want=3", rs_if.issue_result_reg_addr); end
      checks++; if (rs_if.issue_control !== 3'b101) begin failures++; $display("FAIL basic_control got=%b want=101", rs_if.issue_control); end
      checks++; if (rs_if.occupancy !== 3'd1) begin failures++; $display("FAIL basic_occupancy got=%0d want=1", rs_if.occupancy); end
      step();
      checks++; if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL basic_drained_valid got=%0b want=0", rs_if.issue_valid); end
      checks++; if (rs_if.occupancy !== 3'd0) begin failures++; $display("FAIL basic_drained_occupancy got=%0d want=0", rs_if.occupancy); end
      rs_if.issue_ready = 1'b0;
   endtask

   task automatic test_cdb_wakeup();
      rs_if.issue_ready = 1'b1;
      set_dispatch(1'b1, 32'd20, 5'd0, 1'b0, 32'hDEAD_BEEF, 5'd9, 5'd7, 3'b000);
      step();
      rs_if.dispatch_valid = 1'b0;
      set_cdb(1'b1, 5'd8, 32'd77);
      checks++; if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL wake_wrong_tag_valid got=%0b want=0", rs_if.issue_valid); end
      checks++; if (rs_if.occupancy !== 3'd1) begin failures++; $display("FAIL wake_occupancy got=%0d want=1", rs_if.occupancy); end
      step();
      set_cdb(1'b1, 5'd9, 32'd5);
`ifdef DIV_RS_CDB_FORWARD_EN
      checks++; if (rs_if.issue_valid !== 1'b1) begin failures++; $display("FAIL wake_fwd_valid got=%0b want=1", rs_if.issue_valid); end
      checks++; if (rs_if.issue_op2 !== 32'd5) begin failures++; $display("FAIL wake_fwd_op2 got=%0d want=5", rs_if.issue_op2); end
      checks++; if (rs_if.issue_op1 !== 32'd20) begin failures++; $display("FAIL wake_fwd_op1 got=%0d want=20", rs_if.issue_op1); end
      step();
      set_cdb(1'b0, 5'd0, 32'd0);
      checks++; if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL wake_fwd_done_valid got=%0b want=0", rs_if.issue_valid); end
`else
      checks++; if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL wake_capture_cycle_valid got=%0b want=0", rs_if.issue_valid); end
      step();
      set_cdb(1'b0, 5'd0, 32'd0);
      checks++; if (rs_if.issue_valid !== 1'b1) begin failures++; $display("FAIL wake_valid got=%0b want=1", rs_if.issue_valid); end
      checks++; if (rs_if.issue_op2 !== 32'd5) begin failures++; $display("FAIL wake_op2 got=%0d want=5", rs_if.issue_op2); end
      checks++; if (rs_if.issue_op1 !== 32'd20) begin failures++; $display("FAIL wake_op1 got=%0d want=20", rs_if.issue_op1); end
      checks++; if (rs_if.issue_rs_id !== 5'd0) begin failures++; $display("FAIL wake_rs_id got=%0d want=0", rs_if.issue_rs_id); end
      step();
`endif
      checks++; if (rs_if.occupancy !== 3'd0) begin failures++; $display("FAIL wake_drained_occupancy got=%0d want=0", rs_if.occupancy); end
      rs_if.issue_ready = 1'b0;
   endtask

   task automatic test_full();
      rs_if.issue_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         set_dispatch(1'b1, 32'(i + 1), 5'd0, 1'b1, 32'(i + 10), 5'd0, 5'(i), 3'b000);
         checks++; if (rs_if.dispatch_rs_id !== 5'(i)) begin failures++; $display("FAIL full_alloc_rs_id got=%0d want=%0d", rs_if.dispatch_rs_id, i); end
         step();
      end
      rs_if.dispatch_valid = 1'b0;
      checks++; if (rs_if.dispatch_ready !== 1'b0) begin failures++; $display("FAIL full_dispatch_ready got=%0b want=0", rs_if.dispatch_ready); end
      checks++; if (rs_if.occupancy !== 3'd4) begin failures++; $display("FAIL full_occupancy got=%0d want=4", rs_if.occupancy); end
      checks++; if (rs_if.issue_rs_id !== 5'd0) begin failures++; $display("FAIL full_issue_rs_id got=%0d want=0", rs_if.issue_rs_id); end
      // Dispatch while full is refused even though entry 0 issues in the same cycle.
      set_dispatch(1'b1, 32'd999, 5'd0, 1'b1, 32'd9, 5'd0, 5'd9, 3'b000);
      rs_if.issue_ready = 1'b1;
      step();
      rs_if.dispatch_valid = 1'b0;
      rs_if.issue_ready    = 1'b0;
      checks++; if (rs_if.occupancy !== 3'd3) begin failures++; $display("FAIL full_no_overwrite_occupancy got=%0d want=3", rs_if.occupancy); end
      checks++; if (rs_if.dispatch_ready !== 1'b1) begin failures++; $display("FAIL full_freed_ready got=%0b want=1", rs_if.dispatch_ready); end
      checks++; if (rs_if.dispatch_rs_id !== 5'd0) begin failures++; $display("FAIL full_freed_rs_id got=%0d want=0", rs_if.dispatch_rs_id); end
      checks++; if (rs_if.issue_op1 !== 32'd2) begin failures++; $display("FAIL full_next_op1 got=%0d want=2", rs_if.issue_op1); end
      set_dispatch(1'b1, 32'd50, 5'd0, 1'b1, 32'd5, 5'd0, 5'd4, 3'b000);
      step();
      rs_if.dispatch_valid = 1'b0;
      checks++; if (rs_if.occupancy !== 3'd4) begin failures++; $display("FAIL full_reuse_occupancy got=%0d want=4", rs_if.occupancy); end
      checks++; if (rs_if.issue_rs_id !== 5'd0) begin failures++; $display("FAIL full_reuse_rs_id got=%0d want=0", rs_if.issue_rs_id); end
      checks++; if (rs_if.issue_op1 !== 32'd50) begin failures++; $display("FAIL full_reuse_op1 got=%0d want=50", rs_if.issue_op1); end
      rs_if.issue_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) step();
      rs_if.issue_ready = 1'b0;
      checks++; if (rs_if.occupancy !== 3'd0) begin failures++; $display("FAIL full_drain_occupancy got=%0d want=0", rs_if.occupancy); end
   endtask

   task automatic test_dispatch_snoop();
      rs_if.issue_ready = 1'b0;
      set_dispatch(1'b0, 32'h1234_5678, 5'd3, 1'b1, 32'd2, 5'd0, 5'd1, 3'b100);
      set_cdb(1'b1, 5'd3, 32'hFFFF_FFF9);
      step();
      rs_if.dispatch_valid = 1'b0;
      set_cdb(1'b0, 5'd0, 32'd0);
      checks++; if (rs_if.issue_valid !== 1'b1) begin failures++; $display("FAIL snoop_valid got=%0b want=1", rs_if.issue_valid); end
      checks++; if (rs_if.issue_op1 !== 32'hFFFF_FFF9) begin failures++; $display("FAIL snoop_op1 got=%h want=fffffff9", rs_if.issue_op1); end
      checks++; if (rs_if.issue_op2 !== 32'd2) begin failures++; $display("FAIL snoop_op2 got=%0d want=2", rs_if.issue_op2); end
      rs_if.issue_ready = 1'b1;
      step();
      rs_if.issue_ready = 1'b0;
      set_dispatch(1'b0, 32'hDEAD_0001, 5'd4, 1'b0, 32'hDEAD_0002, 5'd4, 5'd2, 3'b000);
      set_cdb(1'b1, 5'd4, 32'd12);
      step();
      rs_if.dispatch_valid = 1'b0;
      set_cdb(1'b0, 5'd0, 32'd0);
      checks++; if (rs_if.issue_valid !== 1'b1) begin failures++; $display("FAIL snoop_both_valid got=%0b want=1", rs_if.issue_valid); end
      checks++; if (rs_if.issue_op1 !== 32'd12) begin failures++; $display("FAIL snoop_both_op1 got=%0d want=12", rs_if.issue_op1); end
      checks++; if (rs_if.issue_op2 !== 32'd12) begin failures++; $display("FAIL snoop_both_op2 got=%0d want=12", rs_if.issue_op2); end
      rs_if.issue_ready = 1'b1;
      step();
      rs_if.issue_ready = 1'b0;
      checks++; if (rs_if.occupancy !== 3'd0) begin failures++; $display("FAIL snoop_drained_occupancy got=%0d want=0", rs_if.occupancy); end
   endtask

   task automatic test_hold_order();
      rs_if.issue_ready = 1'b0;
      set_dispatch(1'b1, 32'd11, 5'd0, 1'b1, 32'd1, 5'd0, 5'd10, 3'b000);
      step();
      set_dispatch(1'b0, 32'd0, 5'd20, 1'b1, 32'd2, 5'd0, 5'd11, 3'b000);
      step();
      set_dispatch(1'b1, 32'd33, 5'd0, 1'b1, 32'd3, 5'd0, 5'd12, 3'b000);
      step();
      rs_if.dispatch_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checks++; if (rs_if.issue_valid !== 1'b1 || rs_if.issue_rs_id !== 5'd0 || rs_if.issue_op1 !== 32'd11)
            begin failures++; $display("FAIL hold_stable cycle=%0d got valid=%0b id=%0d op1=%0d want valid=1 id=0 op1=11", k, rs_if.issue_valid, rs_if.issue_rs_id, rs_if.issue_op1); end
         step();
      end
      rs_if.issue_ready = 1'b1;
      step();
      checks++; if (rs_if.issue_rs_id !== 5'd2) begin failures++; $display("FAIL order_second_rs_id got=%0d want=2", rs_if.issue_rs_id); end
      checks++; if (rs_if.issue_op1 !== 32'd33) begin failures++; $display("FAIL order_second_op1 got=%0d want=33", rs_if.issue_op1); end
      step();
      rs_if.issue_ready = 1'b0;
      checks++; if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL order_pending_valid got=%0b want=0", rs_if.issue_valid); end
      checks++; if (rs_if.occupancy !== 3'd1) begin failures++; $display("FAIL order_pending_occupancy got=%0d want=1", rs_if.occupancy); end
   endtask

   task automatic test_flush();
      // Entry 1 is still waiting on tag 20, so new dispatches land in entries 0 and 2.
      set_dispatch(1'b1, 32'd40, 5'd0, 1'b1, 32'd4, 5'd0, 5'd13, 3'b000);
      checks++; if (rs_if.dispatch_rs_id !== 5'd0) begin failures++; $display("FAIL flush_alloc_a got=%0d want=0", rs_if.dispatch_rs_id); end
      step();
      set_dispatch(1'b1, 32'd41, 5'd0, 1'b1, 32'd4, 5'd0, 5'd14, 3'b000);
      checks++; if (rs_if.dispatch_rs_id !== 5'd2) begin failures++; $display("FAIL flush_alloc_b got=%0d want=2", rs_if.dispatch_rs_id); end
      step();
      checks++; if (rs_if.occupancy !== 3'd3) begin failures++; $display("FAIL flush_pre_occupancy got=%0d want=3", rs_if.occupancy); end
      rs_if.flush       = 1'b1;
      rs_if.issue_ready = 1'b1;
      set_dispatch(1'b1, 32'd42, 5'd0, 1'b1, 32'd4, 5'd0, 5'd15, 3'b000);
      step();
      rs_if.flush          = 1'b0;
      rs_if.dispatch_valid = 1'b0;
      rs_if.issue_ready    = 1'b0;
      checks++; if (rs_if.occupancy !== 3'd0) begin failures++; $display("FAIL flush_occupancy got=%0d want=0", rs_if.occupancy); end
      checks++; if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL flush_issue_valid got=%0b want=0", rs_if.issue_valid); end
      checks++; if (rs_if.dispatch_ready !== 1'b1) begin failures++; $display("FAIL flush_dispatch_ready got=%0b want=1", rs_if.dispatch_ready); end
      checks++; if (rs_if.dispatch_rs_id !== 5'd0) begin failures++; $display("FAIL flush_dispatch_rs_id got=%0d want=0", rs_if.dispatch_rs_id); end
      step();
      checks++; if (rs_if.occupancy !== 3'd0) begin failures++; $display("FAIL flush_settled_occupancy got=%0d want=0", rs_if.occupancy); end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_basic_issue();
      test_cdb_wakeup();
      test_full();
      test_dispatch_snoop();
      test_hold_order();
      test_flush();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
